cargador_instr: RTL and testbench
=================================

// Module: cargador_instr
// PURPOSE
//  Instruction encoder/loader: the write-side counterpart of the immediate extractor in the datapath.
//  Accepts decoded fields (type, opcode, funct, registers, immediate) over a valid/ready handshake.
//  Packs each one into a 32-bit RV32I word (R/I/S formats) and writes it to consecutive instruction-memory addresses.
//  Used by the bench/boot path to build programs. Extracting the immediate from a written word returns the original immediate.
// PARAMETERS
//  ADDR_W     8    instruction-memory word-address width
//  DEPTH      256  max words per load session (<= 2**ADDR_W)
//  BASE_ADDR  0    first word address written after start
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       pulse: clear counters, begin session at BASE_ADDR
//  stop       in   1       pulse: end session after any pending write
//  in_valid   in   1       field bundle valid
//  in_ready   out  1       block can accept a bundle this cycle
//  in_tipo    in   2       00 R-type, 01 I-type (addi/lw), 10 S-type (sw), 11 illegal
//  in_opcode  in   7       opcode[6:0]
//  in_funct3  in   3       funct3
//  in_funct7  in   7       funct7 (R-type only)
//  in_rd      in   5       rd (R/I)
//  in_rs1     in   5       rs1
//  in_rs2     in   5       rs2 (R/S)
//  in_imm     in   32      signed immediate (I/S)
//  mem_we     out  1       instruction-memory write strobe
//  mem_addr   out  ADDR_W  write address
//  mem_wdata  out  32      encoded instruction
//  count      out  ADDR_W+1 words written this session
//  busy       out  1       state==RUN
//  done       out  1       state==DONE; held until next start
//  err_tipo   out  1       1-cycle pulse: illegal in_tipo was accepted
//  err_imm    out  1       1-cycle pulse: immediate out of range (IMM_CHECK_EN only)
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE; all outputs 0; mem_addr=BASE_ADDR.
//  FSM: IDLE -start-> RUN; RUN -(stop | accepted==DEPTH)-> DONE once no write is pending; DONE -start-> RUN.
//  start in any state has priority: clears count/accepted, drops any pending write (no mem_we next cycle), enters RUN.
//  in_ready = (state==RUN) & (accepted<DEPTH) & ~stop_seen. A bundle is accepted when in_valid & in_ready.
//  Latency 1: a bundle accepted in cycle N gives mem_we=1 in cycle N+1. Throughput is 1 word/cycle.
//  mem_addr = BASE_ADDR + count; count increments with each mem_we.
//  Encoding:
//    R: {funct7,rs2,rs1,funct3,rd,opcode}
//    I: {imm[11:0],rs1,funct3,rd,opcode}
//    S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
//  tipo 11: err_tipo pulses in N+1; no write; count unchanged; the bundle still counts toward accepted.
//  Full: after the DEPTH-th accept, in_ready drops next cycle; the final write completes; then DONE.
//  stop in the same cycle as an accept: that word is written, then DONE. stop in IDLE/DONE: ignored.
//  Reset mid-session: immediate abort; no partial write is emitted after release.
// CONFIGURATION
//  IMM_CHECK_EN defined:
//    I/S bundles with in_imm outside [-2048,2047] pulse err_imm in N+1 and are not written.
//  IMM_CHECK_EN undefined:
//    in_imm is silently truncated to [11:0]; err_imm is tied 0.
// STRUCTURE
//  Package cargador_pkg: TIPO_R/TIPO_I/TIPO_S/TIPO_ILEGAL codes, state enum (IDLE, RUN, DONE),
//  and localparams IMM_MIN=-2048, IMM_MAX=2047.
//  Sub-module empaquetador_instr: combinational field->word packer, plus the range flag. The FSM, counters and output register stay in the top.
// TESTING
//  1 I-type addi x1,x0,5 (op 0010011,f3 000,rd 1,rs1 0,imm 5) -> mem_we at N+1, addr 0, wdata 0x00500093
//  2 S-type sw x2,8(x1) (op 0100011,f3 010) then I-type lw x5,-1(x1) (op 0000011,f3 010) back-to-back
//    -> addr0=0x0020A423, addr1=0xFFF0A283, count=2
//  3 R-type add x3,x1,x2 then sub (f7 0100000) -> 0x002081B3, 0x402081B3
//  4 in_tipo=11 -> err_tipo pulse, no mem_we, count unchanged; imm=2048 I-type with IMM_CHECK_EN -> err_imm, no write
//  5 DEPTH=4: stream 6 bundles with in_valid held 1 -> exactly 4 writes at addr 0..3, in_ready=0 after 4th, done=1
//  6 assert rst_n=0 mid-stream, then start -> outputs 0 during reset; new session begins at BASE_ADDR, count=0

Source files
------------

// File: rtl/cargador_pkg.sv
// Shared types for the instruction loader: field-bundle type codes,
// FSM states and the signed 12-bit immediate range.
package cargador_pkg;

  typedef enum logic [1:0] {
    TIPO_R      = 2'b00,
    TIPO_I      = 2'b01,
    TIPO_S      = 2'b10,
    TIPO_ILEGAL = 2'b11
  } tipo_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } estado_e;

  localparam int IMM_MIN = -2048;
  localparam int IMM_MAX = 2047;

endpackage

// File: rtl/empaquetador_instr.sv
// Combinational RV32I R/I/S field packer plus immediate range flag.
// Range flag is only live when IMM_CHECK_EN is defined.
module empaquetador_instr
  import cargador_pkg::*;
(
  input  logic [1:0]  tipo,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        fuera
);

  always_comb begin
    word = '0;
    unique case (tipo)
      TIPO_R:
        word = {funct7, rs2, rs1, funct3, rd, opcode};
      TIPO_I:
        word = {imm[11:0], rs1, funct3, rd, opcode};
      TIPO_S:
        word = {imm[11:5], rs2, rs1, funct3,
                imm[4:0], opcode};
      TIPO_ILEGAL:
        word = '0;
    endcase
  end

`ifdef IMM_CHECK_EN
  logic es_is;
  assign es_is = (tipo == TIPO_I) || (tipo == TIPO_S);
  assign fuera = es_is &&
                 (($signed(imm) < IMM_MIN) ||
                  ($signed(imm) > IMM_MAX));
`else
  // Upper immediate bits are simply dropped in this build.
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:12];
  assign fuera = 1'b0;
`endif

endmodule

// File: rtl/cargador_instr.sv
// Instruction loader: packs field bundles into RV32I words and writes
// them to consecutive addresses. Optional IMM_CHECK_EN range check.
module cargador_instr
  import cargador_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_tipo,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err_tipo,
  output logic              err_imm
);

  localparam logic [ADDR_W:0] DEPTH_C =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C =
    ADDR_W'(BASE_ADDR);

  estado_e         state, state_nx;
  logic [ADDR_W:0] accepted;
  logic            stop_seen;
  logic            full;
  logic            acc;
  logic            legal;
  logic [31:0]     word;
  logic            fuera;

  empaquetador_instr u_pack (
    .tipo   (in_tipo),
    .opcode (in_opcode),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .word   (word),
    .fuera  (fuera)
  );

  assign full     = (accepted == DEPTH_C);
  assign in_ready = (state == RUN) && !full && !stop_seen;
  assign acc      = in_valid && in_ready;
  assign legal    = (in_tipo != TIPO_ILEGAL);
  assign mem_addr = BASE_C + count[ADDR_W-1:0];
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // The write launched last cycle completes at this edge, so the
  // session may close as soon as nothing more can be accepted.
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = RUN;
    end else begin
      unique case (state)
        RUN:     if (stop_seen || full) state_nx = DONE;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      accepted  <= '0;
      count     <= '0;
      stop_seen <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      err_tipo  <= 1'b0;
      err_imm   <= 1'b0;
    end else begin
      state    <= state_nx;
      mem_we   <= 1'b0;
      err_tipo <= 1'b0;
      err_imm  <= 1'b0;
      if (start) begin
        accepted  <= '0;
        count     <= '0;
        stop_seen <= 1'b0;
      end else begin
        if (mem_we) count <= count + 1'b1;
        if (stop && state == RUN) stop_seen <= 1'b1;
        if (acc) begin
          accepted  <= accepted + 1'b1;
          mem_we    <= legal && !fuera;
          mem_wdata <= word;
          err_tipo  <= !legal;
          err_imm   <= fuera;
        end
      end
    end
  end

endmodule

// File: tb/tb_cargador_instr.sv
// Directed bench for cargador_instr (DEPTH=4); expectations adapt to
// IMM_CHECK_EN when that macro is defined.
module tb_cargador_instr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, in_valid, in_ready;
  logic [1:0]  in_tipo;
  logic [6:0]  in_opcode, in_funct7;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;
  logic        busy, done, err_tipo, err_imm;

  int n_chk = 0;
  int n_fail = 0;
  int n_et = 0;
  int n_ei = 0;
  logic [7:0]  qa[$];
  logic [31:0] qd[$];

  cargador_instr #(
    .ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_tipo(in_tipo), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .count(count), .busy(busy),
    .done(done), .err_tipo(err_tipo), .err_imm(err_imm)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      qa.push_back(mem_addr);
      qd.push_back(mem_wdata);
    end
    if (err_tipo) n_et++;
    if (err_imm) n_ei++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic fields(input logic [1:0] t,
                        input logic [6:0] op,
                        input logic [2:0] f3,
                        input logic [6:0] f7,
                        input logic [4:0] rd,
                        input logic [4:0] rs1,
                        input logic [4:0] rs2,
                        input logic [31:0] imm);
    in_tipo = t; in_opcode = op; in_funct3 = f3;
    in_funct7 = f7; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] t,
                     input logic [6:0] op,
                     input logic [2:0] f3,
                     input logic [6:0] f7,
                     input logic [4:0] rd,
                     input logic [4:0] rs1,
                     input logic [4:0] rs2,
                     input logic [31:0] imm);
    fields(t, op, f3, f7, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic go;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    qa.delete();
    qd.delete();
    n_et = 0;
    n_ei = 0;
  endtask

  initial begin
    logic [5:0] rdy;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    in_valid = 1'b0;
    fields(2'b00, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick(2);
    @(negedge clk);
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_busy_done", {busy, done}, 0);
    check("rst_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);

    // 1: addi x1,x0,5 with one-cycle latency
    go();
    fields(2'b01, 7'b0010011, 3'b000, 7'd0,
           5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1;
    @(negedge clk);
    check("t1_ready", 32'(in_ready), 1);
    check("t1_we_early", 32'(mem_we), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_we", 32'(mem_we), 1);
    check("t1_addr", 32'(mem_addr), 0);
    check("t1_data", mem_wdata, 32'h00500093);
    tick(2);
    check("t1_count", 32'(count), 1);

    // 2: sw x2,8(x1) then lw x5,-1(x1)
    go();
    put(2'b10, 7'b0100011, 3'b010, 7'd0,
        5'd0, 5'd1, 5'd2, 32'd8);
    put(2'b01, 7'b0000011, 3'b010, 7'd0,
        5'd5, 5'd1, 5'd0, 32'hFFFF_FFFF);
    tick(3);
    check("t2_nwr", 32'(qa.size()), 2);
    if (qa.size() == 2) begin
      check("t2_a0", 32'(qa[0]), 0);
      check("t2_d0", qd[0], 32'h0020A423);
      check("t2_a1", 32'(qa[1]), 1);
      check("t2_d1", qd[1], 32'hFFF0A283);
    end
    check("t2_count", 32'(count), 2);

    // 3: add x3,x1,x2 then sub
    go();
    put(2'b00, 7'b0110011, 3'b000, 7'b0000000,
        5'd3, 5'd1, 5'd2, 32'd0);
    put(2'b00, 7'b0110011, 3'b000, 7'b0100000,
        5'd3, 5'd1, 5'd2, 32'd0);
    tick(3);
    check("t3_nwr", 32'(qd.size()), 2);
    if (qd.size() == 2) begin
      check("t3_d0", qd[0], 32'h002081B3);
      check("t3_d1", qd[1], 32'h402081B3);
    end
    check("t3_count", 32'(count), 2);

    // 4: illegal type, then out-of-range immediate
    go();
    put(2'b11, 7'b0010011, 3'b000, 7'd0,
        5'd1, 5'd0, 5'd0, 32'd5);
    tick(3);
    check("t4_errt", 32'(n_et), 1);
    check("t4_nwr", 32'(qa.size()), 0);
    check("t4_count", 32'(count), 0);
    put(2'b01, 7'b0010011, 3'b000, 7'd0,
        5'd1, 5'd0, 5'd0, 32'd2048);
    tick(3);
`ifdef IMM_CHECK_EN
    check("t4_erri", 32'(n_ei), 1);
    check("t4_nwr_imm", 32'(qa.size()), 0);
    check("t4_count_imm", 32'(count), 0);
`else
    check("t4_erri", 32'(n_ei), 0);
    check("t4_nwr_imm", 32'(qa.size()), 1);
    if (qd.size() == 1)
      check("t4_trunc", qd[0], 32'h80000093);
`endif

    // 5: six bundles against DEPTH=4
    go();
    fields(2'b01, 7'b0010011, 3'b000, 7'd0,
           5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rdy[i] = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tick(2);
    check("t5_ready", 32'(rdy), 32'h0F);
    check("t5_nwr", 32'(qa.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < qa.size())
        check($sformatf("t5_a%0d", i), 32'(qa[i]), i);
    check("t5_done", {busy, done}, 1);
    check("t5_count", 32'(count), 4);

    // stop together with an accept
    go();
    in_valid = 1'b1;
    stop = 1'b1;
    tick(1);
    in_valid = 1'b0;
    stop = 1'b0;
    tick(3);
    check("stop_nwr", 32'(qa.size()), 1);
    check("stop_done", {busy, done}, 1);

    // 6: reset mid-stream, then restart
    go();
    in_valid = 1'b1;
    tick(2);
    rst_n = 1'b0;
    qa.delete();
    @(negedge clk);
    check("t6_we", 32'(mem_we), 0);
    check("t6_count", 32'(count), 0);
    check("t6_flags", {in_ready, busy, done, err_tipo}, 0);
    check("t6_wdata", mem_wdata, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);
    check("t6_nwr", 32'(qa.size()), 0);
    go();
    check("t6_busy", 32'(busy), 1);
    check("t6_addr", 32'(mem_addr), 0);
    put(2'b01, 7'b0010011, 3'b000, 7'd0,
        5'd1, 5'd0, 5'd0, 32'd5);
    tick(2);
    check("t6_nwr2", 32'(qa.size()), 1);
    if (qa.size() > 0)
      check("t6_a0", 32'(qa[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
